// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUB_BORROW_IN_EN adds the borrow_in request field.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BORROW_IN_EN
  logic             borrow_in;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

`ifdef SERIAL_SUB_BORROW_IN_EN
  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
  );
  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through a single full-subtractor slice.
// Optional feature macro: SERIAL_SUB_BORROW_IN_EN seeds the running borrow
// from bus.borrow_in so results can be chained across words.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q;
  logic [WIDTH-2:0] diff_sr_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             borrow_out_q;
  logic [CNT_W-1:0] cnt_q;

  logic             start_ok;
  logic             last_bit;
  logic             init_borrow;
  logic             slice_diff;
  logic             slice_borrow;
  logic [WIDTH-1:0] diff_full;
  logic             busy_d;
  logic             done_d;

  // One full-subtractor slice; returns {borrow, diff}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic d;
    logic bo;
    d  = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
    return {bo, d};
  endfunction

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign init_borrow = bus.borrow_in;
`else
  assign init_borrow = 1'b0;
`endif

  assign {slice_borrow, slice_diff} = full_sub(a_sr_q[0], b_sr_q[0], borrow_q);

  // Accumulated diff bits with the current slice bit on top; once the last
  // bit is in, this is the complete result.
  assign diff_full = {slice_diff, diff_sr_q};

  assign start_ok = (state_q == IDLE) && bus.start;
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      SHIFT:   busy_d = 1'b1;
      DONE:    begin busy_d = 1'b1; done_d = 1'b1; end
      default: ;
    endcase
  end

  // Operand shifters, running borrow and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
    end else if (start_ok) begin
      a_sr_q    <= bus.a;
      b_sr_q    <= bus.b;
      diff_sr_q <= '0;
      borrow_q  <= init_borrow;
      cnt_q     <= '0;
    end else if (state_q == SHIFT) begin
      a_sr_q    <= a_sr_q >> 1;
      b_sr_q    <= b_sr_q >> 1;
      diff_sr_q <= diff_full[WIDTH-1:1];
      borrow_q  <= slice_borrow;
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers: loaded on the edge that enters DONE so they are valid
  // while done is high, then held until the next completed operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else if (last_bit) begin
      diff_q       <= diff_full;
      borrow_out_q <= slice_borrow;
    end
  end

  assign bus.busy       = busy_d;
  assign bus.done       = done_d;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level reference model plus
// directed literal cases and randomized traffic.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic bin_v = 1'b0;

  int errs   = 0;
  int checks = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign bus.borrow_in = bin_v;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: an operation accepted at edge k shows done after edge
  // k+WIDTH, is busy from k through k+WIDTH, and can accept again from k+WIDTH+2.
  int               cyc    = 0;
  int               m_acc  = 0;
  bit               m_pend = 1'b0;
  bit               m_done = 1'b0;
  logic [WIDTH:0]   m_res  = '0;
  logic [WIDTH-1:0] m_diff = '0;
  logic             m_bo   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 1'b0;
      m_done = 1'b0;
      m_diff = '0;
      m_bo   = 1'b0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_pend && cyc == m_acc + WIDTH + 1) begin
        m_pend = 1'b0;
      end else if (!m_pend && bus.start) begin
        m_pend = 1'b1;
        m_acc  = cyc;
`ifdef SERIAL_SUB_BORROW_IN_EN
        m_res  = {1'b0, bus.a} - {1'b0, bus.b} - (WIDTH+1)'(bin_v);
`else
        m_res  = {1'b0, bus.a} - {1'b0, bus.b};
`endif
      end
      if (m_pend && cyc == m_acc + WIDTH) begin
        m_done = 1'b1;
        m_diff = m_res[WIDTH-1:0];
        m_bo   = m_res[WIDTH];
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("model_busy", 32'(bus.busy), 32'(m_pend));
    chk("model_done", 32'(bus.done), 32'(m_done));
    chk("model_diff", 32'(bus.diff), 32'(m_diff));
    chk("model_borrow", 32'(bus.borrow_out), 32'(m_bo));
  end

  // One operation with literal expectations; optional stray start pulse at
  // cycle pulse_at (0 = none) which must be ignored.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic [7:0] ed, input logic eb, input int pulse_at,
                        input string nm);
    int lat;
    int busy_c;
    int ndone;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bin_v     = bi;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bin_v     = 1'($urandom);
    busy_c = bus.busy ? 1 : 0;
    lat    = -1;
    ndone  = 0;
    for (int k = 1; k <= 2 * WIDTH + 4; k++) begin
      @(posedge clk);
      #1;
      if (pulse_at != 0 && k == pulse_at) begin
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_c++;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    bus.start = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(WIDTH));
    chk({nm, "_busy_cycles"}, 32'(busy_c), 32'(WIDTH + 1));
    chk({nm, "_done_count"}, 32'(ndone), 32'd1);
    chk({nm, "_diff"}, 32'(bus.diff), 32'(ed));
    chk({nm, "_borrow"}, 32'(bus.borrow_out), 32'(eb));
  endtask

  initial begin
    int last_done;
    int ndone;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_diff", 32'(bus.diff), 32'd0);
    chk("reset_borrow", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0, "op_05_03");
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0, "op_03_05");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, "op_00_01");
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 0, "op_FF_FF");
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 3, "ignore_mid");
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, WIDTH, "ignore_done");
`ifdef SERIAL_SUB_BORROW_IN_EN
    run_op(8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 0, "bin_05_03");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0, "bin_00_00");
`endif

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    bin_v     = 1'b0;
    last_done = -1;
    ndone     = 0;
    for (int k = 1; k <= 5 * (WIDTH + 2); k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (last_done >= 0) chk("held_period", 32'(k - last_done), 32'(WIDTH + 2));
        chk("held_diff", 32'(bus.diff), 32'h7F);
        chk("held_borrow", 32'(bus.borrow_out), 32'd0);
        last_done = k;
      end
    end
    chk("held_done_count", 32'(ndone), 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2 * WIDTH + 4) @(posedge clk);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_borrow", 32'(bus.borrow_out), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(8'h0A, 8'h0A, 1'b0, 8'h00, 1'b0, 0, "after_reset");

    // randomized traffic, including starts while busy
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      bin_v     = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2 * WIDTH + 4) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

endmodule
